rr_burst_arbiter: RTL

RR_BURST_ARBITER -- requirements
Module: rr_burst_arbiter

---
 rtl/rr_burst_arbiter.sv | 120 ++++++++++++
 1 files changed

// File: rtl/rr_burst_arbiter.sv
// Round-robin burst arbiter: grant held from first beat until last (optional watchdog: ARB_TIMEOUT_EN).
// Latency: one cycle from IDLE to grant; beats pass combinationally while locked; one IDLE bubble between bursts.
// Backpressure: out_ready is routed only to the granted requester's req_ready; the others stay 0.
module rr_burst_arbiter #(
  parameter int N_REQ       = 8,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16,
  localparam int IW         = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ-1:0]        req_last,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    out_valid,
  output logic [DATA_W-1:0]       out_data,
  output logic                    out_last,
  input  logic                    out_ready,
  output logic [IW-1:0]           out_id,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy,
  output logic                    timeout_err
);

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} state_t;

  state_t           state, state_nxt;
  logic [N_REQ-1:0] grant_nxt;
  logic [IW-1:0]    gidx, gidx_nxt;
  logic [IW-1:0]    last_grant, last_grant_nxt;
  logic [IW-1:0]    rr_idx, cand;
  logic             rr_found;
  logic             xfer;
  logic             stall_hit;

  assign busy      = (state == LOCK);
  assign out_id    = gidx;
  assign out_valid = busy & req_valid[gidx];
  assign out_last  = busy & req_last[gidx];
  assign out_data  = req_data[gidx*DATA_W +: DATA_W];
  assign req_ready = out_ready ? grant : '0;
  assign xfer      = out_valid & out_ready;

  // Offsets 1..N_REQ from last_grant: last_grant itself is reached only when nobody else is valid.
  always_comb begin
    rr_found = 1'b0;
    rr_idx   = last_grant;
    cand     = last_grant;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = IW'((int'(last_grant) + k) % N_REQ);
      if (!rr_found && req_valid[cand]) begin
        rr_found = 1'b1;
        rr_idx   = cand;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  logic [7:0] stall_cnt;

  assign stall_hit = busy && !xfer && (stall_cnt == 8'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt   <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= stall_hit;
      if (!busy || xfer || stall_hit) stall_cnt <= '0;
      else                            stall_cnt <= stall_cnt + 8'd1;
    end
  end
`else
  assign stall_hit   = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    gidx_nxt       = gidx;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: begin
        if (rr_found) begin
          state_nxt = LOCK;
          grant_nxt = N_REQ'(1) << rr_idx;
          gidx_nxt  = rr_idx;
        end
      end
      LOCK: begin
        if ((xfer && out_last) || stall_hit) begin
          state_nxt      = IDLE;
          grant_nxt      = '0;
          last_grant_nxt = gidx;
        end
      end
      default: begin
        state_nxt = IDLE;
        grant_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      gidx       <= '0;
      last_grant <= IW'(N_REQ - 1);
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      gidx       <= gidx_nxt;
      last_grant <= last_grant_nxt;
    end
  end

endmodule
